// File: rtl/ddram_arb.sv
// rtl/ddram_arb.sv - four-channel request arbiter driving the ddram bridge strobes
module ddram_arb #(
    parameter bit         RR      = 1'b1,
    parameter logic [3:0] CH_MASK = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [107:0] ch_addr,
    input  logic [127:0] ch_din,
    input  logic [3:0]   ch_rd,
    input  logic [15:0]  ch_wr,
    input  logic [3:0]   ch_16b,
    output logic [127:0] ch_dout,
    output logic [3:0]   ch_ack,
    output logic [26:0]  mem_addr,
    output logic [31:0]  mem_din,
    output logic         mem_rd,
    output logic [3:0]   mem_wr,
    output logic [1:0]   mem_chan,
    output logic         mem_16b,
    input  logic [31:0]  mem_dout,
    input  logic         mem_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     chan_q, chan_d;
    logic [26:0]    addr_q, addr_d;
    logic [31:0]    din_q, din_d;
    logic           b16_q, b16_d;
    logic           rd_q, rd_d;
    logic [3:0]     wr_q, wr_d;
    logic [3:0]     ack_q, ack_d;
    logic [127:0]   dout_q, dout_d;

    logic [3:0]     pending;
    logic [1:0]     gnt;
    logic [3:0]     gnt_wr;

    // First set bit of p searching upward (mod 4) from start.
    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] start);
        logic [1:0] c;
        pick = start;
        for (int j = 3; j >= 0; j--) begin
            c = start + 2'(j);
            if (p[c]) pick = c;
        end
    endfunction

    always_comb begin
        pending = '0;
        for (int i = 0; i < 4; i++) begin
            pending[i] = CH_MASK[i] & (ch_rd[i] | (|ch_wr[4*i +: 4])) & ~ack_q[i];
        end
    end

    assign gnt    = pick(pending, RR ? ptr_q : 2'd0);
    assign gnt_wr = ch_wr[4*gnt +: 4];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        din_d   = din_q;
        b16_d   = b16_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = '0;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                // The ack cycle is skipped so a requester's still-high line is never
                // mistaken for a new request, and a re-raised one is seen next cycle.
                if ((|pending) && !(|ack_q)) begin
                    chan_d = gnt;
                    addr_d = ch_addr[27*gnt +: 27];
                    din_d  = ch_din[32*gnt +: 32];
                    b16_d  = ch_16b[gnt];
                    if (|gnt_wr) wr_d = gnt_wr;
                    else         rd_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (!mem_busy) begin
                    rd_d          = 1'b0;
                    wr_d          = 4'b0;
                    ack_d[chan_q] = 1'b1;
                    if (rd_q) dout_d[32*chan_q +: 32] = mem_dout;
                    ptr_d   = chan_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            chan_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            b16_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= '0;
            ack_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            b16_q   <= b16_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
        end
    end

    assign ch_dout  = dout_q;
    assign ch_ack   = ack_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_rd   = rd_q;
    assign mem_wr   = wr_q;
    assign mem_chan = chan_q;
    assign mem_16b  = b16_q;

endmodule

// File: tb/tb_ddram_arb.sv
// tb/tb_ddram_arb.sv - scoreboard bench for ddram_arb with a behavioural grant model
module tb_ddram_arb;

    typedef struct packed {
        logic [1:0]  chan;
        logic [3:0]  wr;
        logic [26:0] addr;
        logic [31:0] din;
        logic        b16;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [107:0] ch_addr = '0;
    logic [127:0] ch_din = '0;
    logic [3:0]   ch_rd = '0;
    logic [15:0]  ch_wr = '0;
    logic [3:0]   ch_16b = '0;
    logic [127:0] ch_dout;
    logic [3:0]   ch_ack;
    logic [26:0]  mem_addr;
    logic [31:0]  mem_din;
    logic         mem_rd;
    logic [3:0]   mem_wr;
    logic [1:0]   mem_chan;
    logic         mem_16b;
    logic [31:0]  mem_dout = '0;
    logic         mem_busy = 1'b0;

    logic [107:0] fp_ch_addr = {27'h3, 27'h2, 27'h1ABCDE, 27'h0};
    logic [127:0] fp_ch_din = '0;
    logic [3:0]   fp_ch_rd = 4'b1011;
    logic [15:0]  fp_ch_wr = '0;
    logic [3:0]   fp_ch_16b = '0;
    logic [127:0] fp_ch_dout;
    logic [3:0]   fp_ch_ack;
    logic [26:0]  fp_mem_addr;
    logic [31:0]  fp_mem_din;
    logic         fp_mem_rd;
    logic [3:0]   fp_mem_wr;
    logic [1:0]   fp_mem_chan;
    logic         fp_mem_16b;
    logic [31:0]  fp_mem_dout = 32'hC0FFEE01;
    logic         fp_mem_busy = 1'b0;

    ddram_arb #(.RR(1'b1), .CH_MASK(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .ch_addr(ch_addr), .ch_din(ch_din), .ch_rd(ch_rd),
        .ch_wr(ch_wr), .ch_16b(ch_16b), .ch_dout(ch_dout), .ch_ack(ch_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_chan(mem_chan), .mem_16b(mem_16b), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    ddram_arb #(.RR(1'b0), .CH_MASK(4'hE)) dut_fp (
        .clk(clk), .rst_n(rst_n), .ch_addr(fp_ch_addr), .ch_din(fp_ch_din), .ch_rd(fp_ch_rd),
        .ch_wr(fp_ch_wr), .ch_16b(fp_ch_16b), .ch_dout(fp_ch_dout), .ch_ack(fp_ch_ack),
        .mem_addr(fp_mem_addr), .mem_din(fp_mem_din), .mem_rd(fp_mem_rd), .mem_wr(fp_mem_wr),
        .mem_chan(fp_mem_chan), .mem_16b(fp_mem_16b), .mem_dout(fp_mem_dout), .mem_busy(fp_mem_busy)
    );

    // stimulus-owned
    logic [3:0]   req_rd = '0;
    logic [15:0]  req_wr = '0;
    logic [107:0] req_addr = '0;
    logic [127:0] req_din = '0;
    logic [3:0]   req_16b = '0;
    int           round_id = 0;
    int           force_b = -1;
    bit           use_fd = 1'b0;
    bit           sb_off = 1'b0;
    bit           final_chk = 1'b0;
    int           m_ptr = 0;
    exp_t         exp_arr [0:511];
    int           wr_idx = 0;
    int           acks_exp = 0;

    // monitor-owned
    int           checks = 0;
    int           errors = 0;
    int           rd_idx = 0;
    int           acks_seen = 0;
    bit           mon_done = 1'b0;

    // responder-owned
    int           seen_round = -1;
    int           rk = 0;
    int           rb = 0;
    bit           r_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (round_id != seen_round) begin
            seen_round = round_id;
            ch_rd   = req_rd;
            ch_wr   = req_wr;
            ch_addr = req_addr;
            ch_din  = req_din;
            ch_16b  = req_16b;
        end
        if (!rst_n) begin
            mem_busy = 1'b0;
            rk       = 0;
        end else if ((mem_rd || mem_wr != 0) && !r_prev) begin
            rk       = 1;
            rb       = (force_b >= 0) ? force_b : int'($urandom_range(0, 3));
            mem_dout = use_fd ? 32'hDEADBEEF : $urandom;
            mem_busy = (rb > 0);
        end else if (mem_rd || mem_wr != 0) begin
            rk++;
            mem_busy = (rb > 0) && (rk <= 2 + rb);
        end else begin
            mem_busy = 1'b0;
        end
        r_prev = rst_n && (mem_rd || mem_wr != 0);
        for (int i = 0; i < 4; i++) begin
            if (ch_ack[i]) begin
                ch_rd[i]        = 1'b0;
                ch_wr[4*i +: 4] = 4'b0;
            end
        end
    end

    bit          m_prev = 1'b0;
    bit          f_prev = 1'b0;
    bit          in_xfer = 1'b0;
    int          cyc = 0;
    int          scyc = 0;
    int          xb = 0;
    logic [31:0] xd = '0;
    logic [66:0] snap = '0;
    exp_t        cur = '0;
    logic [31:0] dmodel [4] = '{default: '0};
    int          wdog = 0;
    int          fp_acks = 0;

    always @(negedge clk) begin
        logic        strobe;
        logic [66:0] now;
        logic [64:0] got_p, exp_p;
        logic [127:0] dm;
        strobe = mem_rd || (mem_wr != 0);
        now    = {mem_addr, mem_din, mem_chan, mem_16b, mem_rd, mem_wr};
        if (!rst_n) begin
            checks++;
            if ({ch_dout, ch_ack, now} != '0 || {fp_ch_ack, fp_mem_rd, fp_mem_chan} != '0) begin
                errors++;
                $display("FAIL reset_outputs got ack=%h rd=%b wr=%h chan=%0d addr=%h required all zero",
                         ch_ack, mem_rd, mem_wr, mem_chan, mem_addr);
            end
            in_xfer = 1'b0;
            m_prev  = 1'b0;
            f_prev  = 1'b0;
            for (int i = 0; i < 4; i++) dmodel[i] = '0;
        end else begin
            if (strobe && !m_prev) begin
                in_xfer = 1'b1;
                cyc = 1; scyc = 1; xb = rb; xd = mem_dout; snap = now;
                if (!sb_off) begin
                    checks++;
                    if (rd_idx == wr_idx) begin
                        errors++;
                        $display("FAIL unexpected_grant got chan=%0d required no transfer", mem_chan);
                    end else begin
                        cur = exp_arr[rd_idx];
                        rd_idx++;
                        if (mem_chan != cur.chan) begin
                            errors++;
                            $display("FAIL grant_chan got %0d required %0d", mem_chan, cur.chan);
                        end
                        checks++;
                        got_p = {mem_wr, mem_rd, mem_addr, mem_din, mem_16b};
                        exp_p = {cur.wr, cur.wr == 4'b0, cur.addr, cur.din, cur.b16};
                        if (got_p != exp_p) begin
                            errors++;
                            $display("FAIL grant_payload got %h required %h", got_p, exp_p);
                        end
                    end
                end
            end else if (in_xfer) begin
                cyc++;
                if (strobe) begin
                    scyc++;
                    checks++;
                    if (now != snap) begin
                        errors++;
                        $display("FAIL hold_stable got %h required %h", now, snap);
                    end
                end
            end
            if (sb_off) begin
                checks++;
                if (ch_ack != 0) begin
                    errors++;
                    $display("FAIL dropped_ack got %b required 0000", ch_ack);
                end
            end else if (ch_ack != 0) begin
                checks++;
                if (!in_xfer) begin
                    errors++;
                    $display("FAIL spurious_ack got %b required 0000", ch_ack);
                end else begin
                    if (ch_ack != (4'b1 << cur.chan)) begin
                        errors++;
                        $display("FAIL ack_chan got %b required chan %0d", ch_ack, cur.chan);
                    end
                    checks++;
                    if (cyc != 4 + xb || scyc != 3 + xb || strobe) begin
                        errors++;
                        $display("FAIL latency got ack@%0d strobe=%0d cycles required ack@%0d strobe=%0d",
                                 cyc, scyc, 4 + xb, 3 + xb);
                    end
                    if (cur.wr == 4'b0) dmodel[cur.chan] = xd;
                    dm = {dmodel[3], dmodel[2], dmodel[1], dmodel[0]};
                    checks++;
                    if (ch_dout != dm) begin
                        errors++;
                        $display("FAIL ch_dout got %h required %h", ch_dout, dm);
                    end
                    acks_seen++;
                    in_xfer = 1'b0;
                    wdog = 0;
                end
            end
            if (!sb_off && acks_seen != acks_exp) begin
                wdog++;
                if (wdog > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_timeout got %0d acks required %0d", acks_seen, acks_exp);
                    acks_seen = acks_exp;
                    rd_idx = wr_idx;
                    wdog = 0;
                end
            end else begin
                wdog = 0;
            end
            m_prev = strobe;

            if (fp_mem_rd && !f_prev) begin
                checks++;
                if (fp_mem_chan != 2'd1) begin
                    errors++;
                    $display("FAIL fp_grant got %0d required 1", fp_mem_chan);
                end
            end
            f_prev = fp_mem_rd;
            if (fp_ch_ack != 0) begin
                checks++;
                if (fp_ch_ack != 4'b0010 || fp_ch_dout[63:32] != 32'hC0FFEE01) begin
                    errors++;
                    $display("FAIL fp_ack got ack=%b dout=%h required ack=0010 dout=c0ffee01",
                             fp_ch_ack, fp_ch_dout[63:32]);
                end
                fp_acks++;
            end
        end
        if (final_chk && !mon_done) begin
            checks++;
            if (fp_acks < 10) begin
                errors++;
                $display("FAIL fp_ack_count got %0d required >=10", fp_acks);
            end
            checks++;
            if (rd_idx != wr_idx) begin
                errors++;
                $display("FAIL unconsumed_grants got %0d required %0d", rd_idx, wr_idx);
            end
            mon_done = 1'b1;
        end
    end

    task automatic clear_req();
        req_rd = '0; req_wr = '0; req_16b = '0;
    endtask

    task automatic run_round();
        logic [3:0] pend;
        exp_t       e;
        int         c;
        bit         found;
        for (int i = 0; i < 4; i++) pend[i] = req_rd[i] | (req_wr[4*i +: 4] != 0);
        while (pend != 0) begin
            c = 0;
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (!found && pend[(m_ptr + j) % 4]) begin
                    c = (m_ptr + j) % 4;
                    found = 1'b1;
                end
            end
            e.chan = 2'(c);
            e.wr   = req_wr[4*c +: 4];
            e.addr = req_addr[27*c +: 27];
            e.din  = req_din[32*c +: 32];
            e.b16  = req_16b[c];
            exp_arr[wr_idx] = e;
            wr_idx++;
            acks_exp++;
            pend[c] = 1'b0;
            m_ptr = (c + 1) % 4;
        end
        round_id++;
        while (acks_seen != acks_exp) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mode;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        clear_req();
        for (int i = 0; i < 4; i++) begin
            req_rd[i] = 1'b1;
            req_addr[27*i +: 27] = 27'($urandom);
        end
        run_round();
        clear_req();
        req_rd[0] = 1'b1;
        req_addr[26:0] = 27'($urandom);
        run_round();

        clear_req();
        force_b = 0; use_fd = 1'b1;
        req_rd[2] = 1'b1;
        req_addr[54 +: 27] = 27'h0000010;
        run_round();

        clear_req();
        force_b = 5; use_fd = 1'b0;
        req_wr[3:0] = 4'b0011;
        req_16b[0] = 1'b1;
        req_addr[26:0] = 27'h0155AA0;
        req_din[31:0] = 32'h12345678;
        run_round();

        clear_req();
        force_b = -1;
        req_rd[1] = 1'b1;
        req_wr[7:4] = 4'hF;
        req_din[63:32] = 32'hA5A5_0101;
        req_addr[53:27] = 27'h7FFFFFF;
        run_round();

        repeat (25) begin
            clear_req();
            for (int i = 0; i < 4; i++) begin
                mode = int'($urandom_range(0, 3));
                req_rd[i] = (mode == 1 || mode == 3);
                if (mode >= 2) req_wr[4*i +: 4] = 4'($urandom_range(1, 15));
                req_16b[i] = 1'($urandom);
                req_addr[27*i +: 27] = 27'($urandom);
                req_din[32*i +: 32] = $urandom;
            end
            run_round();
        end

        sb_off = 1'b1;
        clear_req();
        force_b = 20;
        req_rd[3] = 1'b1;
        round_id++;
        for (int t = 0; t < 20 && !mem_rd; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_req();
        round_id++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        force_b = -1;
        repeat (15) @(negedge clk);

        final_chk = 1'b1;
        for (int t = 0; t < 5 && !mon_done; t++) @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
